// File: rtl/pixel_addr_gen.sv
// pixel_addr_gen: maps video-timing counters to a frame-buffer read address
// through a fixed 3-stage pipeline (register -> scale -> bounds/mirror/address).
// Scale and mirror settings are captured at frame start (h==0, v==0) so a
// mode change never tears mid-frame.
// Optional feature macro: MIRROR_V_EN enables vertical mirroring; when it is
// undefined, mirror_v_in is ignored and no vertical flip logic is built.
module pixel_addr_gen #(
    parameter int SRC_W  = 240,
    parameter int SRC_H  = 320,
    parameter int H_BITS = 11,
    parameter int V_BITS = 10,
    parameter int ADDR_W = 17
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [H_BITS-1:0] hcount_in,
    input  logic [V_BITS-1:0] vcount_in,
    input  logic              active_in,
    input  logic [1:0]        scale_in,
    input  logic              mirror_h_in,
    input  logic              mirror_v_in,
    output logic [ADDR_W-1:0] pixel_addr_out,
    output logic              addr_valid_out,
    output logic              in_bounds_out
);

    // Divide-by-3 via multiply by ceil(2^K/3) and shift right by K. With
    // K = XW + 2 the rounding error stays below 1/6 for every XW-bit input,
    // so the result is exactly floor(x/3) across the whole counter range.
    localparam int XW = ((H_BITS > V_BITS) ? H_BITS : V_BITS) + 1;
    localparam int K  = XW + 2;
    localparam logic [K-1:0] MUL3 = K'((2 ** K + 2) / 3);

    localparam logic [1:0] SCALE_1X  = 2'd0;
    localparam logic [1:0] SCALE_2X  = 2'd1;
    localparam logic [1:0] SCALE_1P5 = 2'd2;

    function automatic logic [XW-1:0] div3(input logic [XW-1:0] x);
        logic [XW+K-1:0] p;
        p = {{K{1'b0}}, x} * {{XW{1'b0}}, MUL3};
        return XW'(p >> K);
    endfunction

    // Frame-start detection and effective configuration
    logic              frame_start_s;
    logic [1:0]        eff_scale_s;
    logic              eff_mh_s;
    logic [1:0]        shadow_scale_q;
    logic              shadow_mh_q;

    // Stage registers
    logic [H_BITS-1:0] h1_q;
    logic [V_BITS-1:0] v1_q;
    logic              act1_q, mh1_q, act2_q, mh2_q;
    logic [1:0]        scale1_q;
    logic [H_BITS-1:0] sx2_q, sx_d;
    logic [V_BITS-1:0] sy2_q, sy_d;
    logic [ADDR_W-1:0] addr_d;
    logic              inb_d;

    assign frame_start_s = (hcount_in == {H_BITS{1'b0}}) && (vcount_in == {V_BITS{1'b0}});

`ifdef MIRROR_V_EN
    logic eff_mv_s, shadow_mv_q, mv1_q, mv2_q;

    // Vertical mirror follows the same frame-synchronous capture as the rest
    always_comb begin
        eff_mv_s = shadow_mv_q;
        if (frame_start_s) begin
            eff_mv_s = mirror_v_in;
        end else begin
            eff_mv_s = shadow_mv_q;
        end
    end

    // Vertical mirror shadow register and its pipeline copies
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            shadow_mv_q <= 1'b0;
            mv1_q       <= 1'b0;
            mv2_q       <= 1'b0;
        end else begin
            if (frame_start_s) begin
                shadow_mv_q <= mirror_v_in;
            end
            mv1_q <= eff_mv_s;
            mv2_q <= mv1_q;
        end
    end
`else
    // Port kept for interface stability; its value is intentionally dropped
    logic unused_mirror_v_s;
    assign unused_mirror_v_s = mirror_v_in;
`endif

    // Frame-start pixel uses the freshly requested config, others the shadow
    always_comb begin
        eff_scale_s = shadow_scale_q;
        eff_mh_s    = shadow_mh_q;
        if (frame_start_s) begin
            eff_scale_s = scale_in;
            eff_mh_s    = mirror_h_in;
        end else begin
            eff_scale_s = shadow_scale_q;
            eff_mh_s    = shadow_mh_q;
        end
    end

    // Shadow configuration captured only at frame start
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            shadow_scale_q <= SCALE_1X;
            shadow_mh_q    <= 1'b0;
        end else if (frame_start_s) begin
            shadow_scale_q <= scale_in;
            shadow_mh_q    <= mirror_h_in;
        end
    end

    // Stage 2 combinational: source coordinates for the selected scale
    always_comb begin
        sx_d = h1_q;
        sy_d = v1_q;
        case (scale1_q)
            SCALE_1X: begin
                sx_d = h1_q;
                sy_d = v1_q;
            end
            SCALE_2X: begin
                sx_d = h1_q >> 1;
                sy_d = v1_q >> 1;
            end
            SCALE_1P5: begin
                sx_d = H_BITS'(div3(XW'({h1_q, 1'b0})));
                sy_d = V_BITS'(div3(XW'({v1_q, 1'b0})));
            end
            default: begin
                sx_d = h1_q >> 2;
                sy_d = v1_q >> 2;
            end
        endcase
    end

    // Stage 3 combinational: bounds test, mirroring and linear address
    always_comb begin
        logic [ADDR_W-1:0] sx_a;
        logic [ADDR_W-1:0] sy_a;
        sx_a   = ADDR_W'(sx2_q);
        sy_a   = ADDR_W'(sy2_q);
        inb_d  = (32'(sx2_q) < 32'(SRC_W)) && (32'(sy2_q) < 32'(SRC_H));
        addr_d = {ADDR_W{1'b0}};
        if (mh2_q) begin
            sx_a = ADDR_W'(SRC_W - 1) - sx_a;
        end else begin
            sx_a = ADDR_W'(sx2_q);
        end
`ifdef MIRROR_V_EN
        if (mv2_q) begin
            sy_a = ADDR_W'(SRC_H - 1) - sy_a;
        end else begin
            sy_a = ADDR_W'(sy2_q);
        end
`endif
        if (inb_d) begin
            addr_d = sx_a + ADDR_W'(SRC_W) * sy_a;
        end else begin
            addr_d = {ADDR_W{1'b0}};
        end
    end

    // Three pipeline stages ending in registered outputs
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            h1_q           <= {H_BITS{1'b0}};
            v1_q           <= {V_BITS{1'b0}};
            act1_q         <= 1'b0;
            scale1_q       <= SCALE_1X;
            mh1_q          <= 1'b0;
            sx2_q          <= {H_BITS{1'b0}};
            sy2_q          <= {V_BITS{1'b0}};
            act2_q         <= 1'b0;
            mh2_q          <= 1'b0;
            pixel_addr_out <= {ADDR_W{1'b0}};
            addr_valid_out <= 1'b0;
            in_bounds_out  <= 1'b0;
        end else begin
            h1_q           <= hcount_in;
            v1_q           <= vcount_in;
            act1_q         <= active_in;
            scale1_q       <= eff_scale_s;
            mh1_q          <= eff_mh_s;
            sx2_q          <= sx_d;
            sy2_q          <= sy_d;
            act2_q         <= act1_q;
            mh2_q          <= mh1_q;
            pixel_addr_out <= addr_d;
            addr_valid_out <= act2_q;
            in_bounds_out  <= inb_d;
        end
    end

endmodule
